// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier: default operand width
// and the product-width rule.
package mult_pkg;
   localparam int WIDTH_DEF = 8;

   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction
endpackage

// File: rtl/mult_pp_row.sv
// One multiplier row: gates a by b_bit, shifts it by SHIFT and ripple-adds it
// onto the running accumulator through an explicit full-adder chain.
module mult_pp_row
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SHIFT = 0
) (
   input  logic [prod_w(WIDTH)-1:0] acc_in,
   input  logic [WIDTH-1:0]         a,
   input  logic                     b_bit,
   output logic [prod_w(WIDTH)-1:0] acc_out
);
   localparam int PW = prod_w(WIDTH);

   logic [PW-1:0] w_pp;
   logic [PW-1:0] w_c;

   assign w_pp   = PW'({WIDTH{b_bit}} & a) << SHIFT;
   assign w_c[0] = 1'b0;

   // The carry out of the top bit is never built: the full product fits in PW bits.
   for (genvar i = 0; i < PW; i++) begin : g_fa
      assign acc_out[i] = acc_in[i] ^ w_pp[i] ^ w_c[i];
      if (i < PW - 1) begin : g_cy
         assign w_c[i+1] = (acc_in[i] & w_pp[i]) | (w_c[i] & (acc_in[i] ^ w_pp[i]));
      end
   end
endmodule

// File: rtl/mult.sv
// Unsigned WIDTH x WIDTH array multiplier: combinational product on x and a
// one-cycle registered copy on x_q.
module mult
   import mult_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   output logic [prod_w(WIDTH)-1:0] x,
   output logic [prod_w(WIDTH)-1:0] x_q
);
   localparam int PW = prod_w(WIDTH);

   logic [WIDTH:0][PW-1:0] w_acc;
   logic [PW-1:0]          r_x_q;

   assign w_acc[0] = '0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_row
      mult_pp_row #(
         .WIDTH (WIDTH),
         .SHIFT (i)
      ) u_row (
         .acc_in  (w_acc[i]),
         .a       (a),
         .b_bit   (b[i]),
         .acc_out (w_acc[i+1])
      );
   end

   assign x = w_acc[WIDTH];

   always_ff @(posedge clk) begin
      if (rst) r_x_q <= '0;
      else     r_x_q <= x;
   end

   assign x_q = r_x_q;
endmodule

// File: tb/tb_mult.sv
// Directed bench for mult: reset/register path, mid-stream reset, stopped-clock
// combinational behaviour, corners and exhaustive sweeps at WIDTH=8 and WIDTH=4.
module tb_mult;
   logic        clk = 1'b0;
   logic        clk_en = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  a = '0, b = '0;
   logic [15:0] x, x_q;
   logic [3:0]  a4 = '0, b4 = '0;
   logic [7:0]  x4, x4_q;

   int passed = 0;
   int total  = 0;

   mult #(.WIDTH(8)) dut (
      .clk (clk), .rst (rst), .a (a), .b (b), .x (x), .x_q (x_q)
   );

   mult #(.WIDTH(4)) dut4 (
      .clk (clk), .rst (rst), .a (a4), .b (b4), .x (x4), .x_q (x4_q)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      logic [15:0] hold;
      logic [15:0] exp_q;

      // Reset held for two edges: x_q cleared, x still live.
      a = 8'd3; b = 8'd5;
      clk_en = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("rst_xq", x_q, 16'h0000);
      check("rst_x", x, 16'h000F);

      @(negedge clk);
      rst = 1'b0; a = 8'd12; b = 8'd13;
      @(posedge clk); #1;
      check("reg_12x13", x_q, 16'h009C);
      check("comb_12x13", x, 16'h009C);

      // Random stream with a one-edge reset in the middle.
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         a = 8'($urandom_range(255));
         b = 8'($urandom_range(255));
         rst = (k == 6);
         exp_q = rst ? 16'h0000 : 16'(a) * 16'(b);
         @(posedge clk); #1;
         check($sformatf("stream_xq_%0d", k), x_q, exp_q);
         check($sformatf("stream_x_%0d", k), x, 16'(a) * 16'(b));
      end
      @(negedge clk);
      rst = 1'b0;
      a = 8'd7; b = 8'd9;
      @(posedge clk); #1;
      check("resume_xq", x_q, 16'd63);

      // Stop the clock low; x must track inputs, x_q must hold.
      @(negedge clk);
      clk_en = 1'b0;
      hold = x_q;
      a = 8'd100; b = 8'd3;
      #1;
      check("noclk_x", x, 16'd300);
      check("noclk_xq", x_q, hold);

      a = 8'd0;   b = 8'd255; #1; check("c_0x255", x, 16'h0000);
      a = 8'd1;   b = 8'd200; #1; check("c_1x200", x, 16'h00C8);
      a = 8'd255; b = 8'd255; #1; check("c_255x255", x, 16'hFE01);
      a = 8'd128; b = 8'd2;   #1; check("c_128x2", x, 16'h0100);
      a = 8'd16;  b = 8'd16;  #1; check("c_16x16", x, 16'h0100);
      check("noclk_xq_end", x_q, hold);

      for (int i = 0; i < 256; i++) begin
         for (int j = 0; j < 256; j++) begin
            a = 8'(i); b = 8'(j);
            #1;
            if (x !== 16'(i * j)) check($sformatf("sweep8_%0d_%0d", i, j), x, 16'(i * j));
            else begin total++; passed++; end
         end
      end

      a4 = 4'd15; b4 = 4'd15; #1;
      check("w4_15x15", {8'h00, x4}, 16'h00E1);
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            a4 = 4'(i); b4 = 4'(j);
            #1;
            check($sformatf("sweep4_%0d_%0d", i, j), {8'h00, x4}, 16'(i * j));
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
